// File: rtl/nibble_demux_loader.sv
// nibble_demux_loader: 1-to-8 nibble demux filling a frame of slots; optional overrun flag via DEMUX_OVERRUN_EN
module nibble_demux_loader (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic [2:0] sel,
   input  logic       auto_mode,
   input  logic       ack,
   output logic [3:0] y0,
   output logic [3:0] y1,
   output logic [3:0] y2,
   output logic [3:0] y3,
   output logic [3:0] y4,
   output logic [3:0] y5,
   output logic [3:0] y6,
   output logic [3:0] y7,
   output logic [7:0] slot_full,
   output logic [2:0] ptr,
   output logic       frame_done
`ifdef DEMUX_OVERRUN_EN
   ,
   output logic       overrun
`endif
);
   typedef enum logic {LOAD, HOLD} state_t;
   state_t state;
   logic [3:0] y [8];
   logic [2:0] idx;
   logic [7:0] nxt_full;
   always_comb begin
      idx = auto_mode ? ptr : sel;
      nxt_full = slot_full | (8'd1 << idx);
   end
   assign din_ready = (state == LOAD);
   assign y0 = y[0];
   assign y1 = y[1];
   assign y2 = y[2];
   assign y3 = y[3];
   assign y4 = y[4];
   assign y5 = y[5];
   assign y6 = y[6];
   assign y7 = y[7];
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
         for (int i = 0; i < 8; i++) y[i] <= 4'd0;
         slot_full <= 8'd0;
         ptr <= 3'd0;
         frame_done <= 1'b0;
`ifdef DEMUX_OVERRUN_EN
         overrun <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (state == HOLD) begin
            if (ack) begin
               state <= LOAD;
               slot_full <= 8'd0;
               ptr <= 3'd0;
`ifdef DEMUX_OVERRUN_EN
               overrun <= 1'b0;
            end else if (din_valid) begin
               overrun <= 1'b1;
`endif
            end
         end else if (din_valid) begin
            y[idx] <= din;
            slot_full <= nxt_full;
            if (auto_mode) ptr <= ptr + 3'd1;
            if (&nxt_full) begin
               state <= HOLD;
               frame_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_nibble_demux_loader.sv
// tb_nibble_demux_loader: directed and random stimulus checked against a frame-level model
module tb_nibble_demux_loader;
   logic clk = 1'b0;
   logic rst, din_valid, auto_mode, ack;
   logic [3:0] din;
   logic [2:0] sel;
   logic din_ready, frame_done;
   logic [3:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic [7:0] slot_full;
   logic [2:0] ptr;
`ifdef DEMUX_OVERRUN_EN
   logic overrun;
`endif
   logic [3:0] yv [8];
   int errors = 0;
   int checks = 0;
   int m_y [8];
   bit m_full [8];
   int m_ptr, m_fd_cnt = 0;
   bit m_hold, m_fd, m_ovr, live = 0;

   always #5 clk = ~clk;

   nibble_demux_loader dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .sel(sel), .auto_mode(auto_mode), .ack(ack),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
      .slot_full(slot_full), .ptr(ptr), .frame_done(frame_done)
`ifdef DEMUX_OVERRUN_EN
      , .overrun(overrun)
`endif
   );

   assign yv[0] = y0;
   assign yv[1] = y1;
   assign yv[2] = y2;
   assign yv[3] = y3;
   assign yv[4] = y4;
   assign yv[5] = y5;
   assign yv[6] = y6;
   assign yv[7] = y7;

   function automatic logic [7:0] full_vec();
      logic [7:0] v = 8'd0;
      for (int k = 0; k < 8; k++) if (m_full[k]) v = v + (8'd1 << k);
      return v;
   endfunction

   function automatic int filled();
      int n = 0;
      for (int k = 0; k < 8; k++) n += int'(m_full[k]);
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame-level reference: a slot array, a fill count and a hold flag
   always @(posedge clk) begin
      m_fd = 1'b0;
      if (rst) begin
         live = 1'b1;
         for (int k = 0; k < 8; k++) begin
            m_y[k] = 0;
            m_full[k] = 1'b0;
         end
         m_ptr = 0;
         m_hold = 1'b0;
         m_ovr = 1'b0;
      end else if (m_hold) begin
         if (ack) begin
            for (int k = 0; k < 8; k++) m_full[k] = 1'b0;
            m_ptr = 0;
            m_hold = 1'b0;
            m_ovr = 1'b0;
         end else if (din_valid) m_ovr = 1'b1;
      end else if (din_valid) begin
         int t;
         t = auto_mode ? m_ptr : int'(sel);
         m_y[t] = int'(din);
         m_full[t] = 1'b1;
         if (auto_mode) m_ptr = (m_ptr + 1) % 8;
         if (filled() == 8) begin
            m_hold = 1'b1;
            m_fd = 1'b1;
            m_fd_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         for (int k = 0; k < 8; k++) chk($sformatf("y%0d", k), 32'(yv[k]), 32'(m_y[k]));
         chk("slot_full", 32'(slot_full), 32'(full_vec()));
         chk("ptr", 32'(ptr), 32'(m_ptr));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         chk("din_ready", 32'(din_ready), 32'(!m_hold));
`ifdef DEMUX_OVERRUN_EN
         chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
      end
   end

   task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic am,
                        input logic [2:0] s, input logic a);
      rst = r;
      din_valid = v;
      din = d;
      auto_mode = am;
      sel = s;
      ack = a;
      @(negedge clk);
   endtask

   initial begin
      int base;
      logic [2:0] sels [9];
      logic [3:0] dins [9];
      sels = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
      dins = '{4'h2, 4'h3, 4'h4, 4'hA, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
      drive(1, 0, 0, 1, 0, 0);
      drive(1, 1, 4'hF, 1, 0, 1);
      chk("rst_slot_full", 32'(slot_full), 0);
      chk("rst_ptr", 32'(ptr), 0);
      chk("rst_din_ready", 32'(din_ready), 1);
      chk("rst_y7", 32'(y7), 0);
      // full auto frame
      base = m_fd_cnt;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 4'(i + 1), 1, 3'($urandom_range(0, 7)), 0);
         if (i == 6) chk("auto_no_early_done", 32'(frame_done), 0);
      end
      chk("auto_done", 32'(frame_done), 1);
      chk("auto_ready", 32'(din_ready), 0);
      chk("auto_ptr_wrap", 32'(ptr), 0);
      chk("auto_y0", 32'(y0), 1);
      chk("auto_y3", 32'(y3), 4);
      chk("auto_y7", 32'(y7), 8);
      chk("auto_full", 32'(slot_full), 32'hFF);
      // writes refused in HOLD, then ack
      drive(0, 1, 4'hF, 1, 0, 0);
      chk("auto_done_one_pulse", 32'(frame_done), 0);
      chk("model_auto_pulses", 32'(m_fd_cnt - base), 1);
`ifdef DEMUX_OVERRUN_EN
      chk("overrun_set", 32'(overrun), 1);
`endif
      drive(0, 1, 4'hF, 0, 3'd2, 0);
      chk("hold_y0", 32'(y0), 1);
      chk("hold_y2", 32'(y2), 3);
      drive(0, 0, 0, 1, 0, 1);
      chk("ack_full", 32'(slot_full), 0);
      chk("ack_ptr", 32'(ptr), 0);
      chk("ack_ready", 32'(din_ready), 1);
      chk("ack_y7", 32'(y7), 8);
`ifdef DEMUX_OVERRUN_EN
      chk("overrun_clr", 32'(overrun), 0);
`endif
      // addressed frame with an overwrite of slot 3
      base = m_fd_cnt;
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, dins[i], 0, sels[i], 0);
         if (i == 7) chk("addr_no_early_done", 32'(frame_done), 0);
      end
      chk("addr_done", 32'(frame_done), 1);
      chk("addr_y3", 32'(y3), 32'hA);
      chk("addr_ptr", 32'(ptr), 0);
      chk("model_addr_pulses", 32'(m_fd_cnt - base), 1);
      // ack with a simultaneous write: write is dropped
      drive(0, 1, 4'h9, 1, 0, 1);
      chk("ackwr_full", 32'(slot_full), 0);
      chk("ackwr_ready", 32'(din_ready), 1);
      chk("ackwr_y0", 32'(y0), 3);
      drive(0, 1, 4'hC, 1, 0, 0);
      chk("after_ack_y0", 32'(y0), 32'hC);
      chk("after_ack_ptr", 32'(ptr), 1);
      // mid-frame reset
      for (int i = 0; i < 4; i++) drive(0, 1, 4'(i + 1), 1, 0, 0);
      chk("pre_rst_ptr", 32'(ptr), 5);
      drive(1, 1, 4'h5, 1, 0, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("midrst_y%0d", k), 32'(yv[k]), 0);
      chk("midrst_full", 32'(slot_full), 0);
      chk("midrst_ptr", 32'(ptr), 0);
      drive(0, 1, 4'h7, 1, 0, 0);
      chk("post_rst_y0", 32'(y0), 7);
      chk("post_rst_full", 32'(slot_full), 1);
      // mode switch mid-frame
      drive(1, 0, 0, 1, 0, 0);
      base = m_fd_cnt;
      for (int i = 0; i < 3; i++) drive(0, 1, 4'(i + 1), 1, 0, 0);
      for (int i = 3; i < 8; i++) begin
         drive(0, 1, 4'(i + 1), 0, 3'(i), 0);
         if (i == 6) chk("mix_no_early_done", 32'(frame_done), 0);
      end
      chk("mix_ptr", 32'(ptr), 3);
      chk("mix_done", 32'(frame_done), 1);
      chk("mix_y5", 32'(y5), 6);
      chk("model_mix_pulses", 32'(m_fd_cnt - base), 1);
      drive(0, 0, 0, 1, 0, 1);
      // random traffic
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, 4'($urandom),
               1'($urandom), 3'($urandom), $urandom_range(0, 4) == 0);
      drive(0, 0, 0, 1, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
